cluster_frame_packer: RTL and testbench

// Downstream neighbour of the first-N-of-1536 cluster finder. It captures the
// 8 clusters (adr/cnt/vpf) presented with the finder's latch_out pulse. It

---
 rtl/cluster_frame_packer_if.sv | 32 +++
 rtl/cluster_frame_packer.sv | 147 ++++++++++++++
 tb/tb_cluster_frame_packer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cluster_frame_packer_if.sv
// Bus between the cluster finder, the frame packer and the trigger-link side.
// Master drives the captured cluster set (latch_in/adr_in/cnt_in/vpf_in);
// slave (the packer) drives the serialised frame and its status outputs.
interface cluster_frame_packer_if #(
  parameter int MXCLUSTERS = 8,
  parameter int MXADRBITS  = 11,
  parameter int MXCNTBITS  = 3
);
  localparam int WW  = MXCNTBITS + MXADRBITS;
  localparam int NCW = $clog2(MXCLUSTERS + 1);

  logic                            latch_in;
  logic [MXCLUSTERS*MXADRBITS-1:0] adr_in;
  logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_in;
  logic [MXCLUSTERS-1:0]           vpf_in;
  logic [2*WW-1:0]                 frame_data;
  logic                            frame_valid;
  logic                            frame_start;
  logic                            frame_overflow;
  logic [NCW-1:0]                  nclusters;
  logic [15:0]                     drop_cnt;

  modport master (
    output latch_in, adr_in, cnt_in, vpf_in,
    input  frame_data, frame_valid, frame_start, frame_overflow, nclusters, drop_cnt
  );

  modport slave (
    input  latch_in, adr_in, cnt_in, vpf_in,
    output frame_data, frame_valid, frame_start, frame_overflow, nclusters, drop_cnt
  );
endinterface

// File: rtl/cluster_frame_packer.sv
// Captures an 8-cluster set on latch_in, formats 14-bit words, sends a 4-beat frame (2 words/beat).
// Latency: latch_in at cycle N -> beat 0 at N+1, beat 3 at N+4 (all outputs registered).
// No backpressure: a set latched while beats 0..2 are in flight is dropped and counted.
// Ports: clock/reset (async, active-high); bus (slave): latch_in, adr_in, cnt_in, vpf_in in;
//        frame_data, frame_valid, frame_start, frame_overflow, nclusters, drop_cnt out.
module cluster_frame_packer #(
  parameter int                   MXCLUSTERS  = 8,
  parameter int                   MXADRBITS   = 11,
  parameter int                   MXCNTBITS   = 3,
  parameter int                   NBEATS      = 4,
  parameter logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FE
) (
  input logic clock,
  input logic reset,
  cluster_frame_packer_if.slave bus
);
  localparam int WW  = MXCNTBITS + MXADRBITS;
  localparam int BW  = $clog2(NBEATS);
  localparam int NCW = $clog2(MXCLUSTERS + 1);
  localparam logic [MXADRBITS-1:0] MAX_ADR   = MXADRBITS'(1535);
  localparam logic [BW-1:0]        LAST_BEAT = BW'(NBEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            capture, drop;

  logic [WW-1:0]   fmt_word [MXCLUSTERS];
  logic [NCW-1:0]  fmt_ncl;
  logic [WW-1:0]   words_q  [MXCLUSTERS];
  logic [WW-1:0]   words_d  [MXCLUSTERS];

  logic            pending_ovf_q, pending_ovf_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [2*WW-1:0] frame_data_q, frame_data_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_overflow_q, frame_overflow_d;
  logic [NCW-1:0]  nclusters_q, nclusters_d;

  // Word formatting and legal-cluster popcount straight off the inputs, so the
  // capture cycle can register beat 0 directly.
  always_comb begin
    fmt_ncl = '0;
    for (int i = 0; i < MXCLUSTERS; i++) begin
      fmt_word[i] = {{MXCNTBITS{1'b0}}, INVALID_ADR};
      if (bus.vpf_in[i] && (bus.adr_in[i*MXADRBITS +: MXADRBITS] <= MAX_ADR)) begin
        fmt_word[i] = {bus.cnt_in[i*MXCNTBITS +: MXCNTBITS], bus.adr_in[i*MXADRBITS +: MXADRBITS]};
        fmt_ncl     = fmt_ncl + NCW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next state: a new set is only accepted when idle or on the last beat.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    capture = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.latch_in) begin
          capture = 1'b1;
          state_d = SEND;
          beat_d  = '0;
        end
      end
      SEND: begin
        if (beat_q != LAST_BEAT) begin
          beat_d = beat_q + BW'(1);
          drop   = bus.latch_in;
        end else if (bus.latch_in) begin
          capture = 1'b1;
          beat_d  = '0;
        end else begin
          state_d = IDLE;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Outputs for the cycle after this edge, computed from the next state.
  always_comb begin
    words_d          = capture ? fmt_word : words_q;
    nclusters_d      = capture ? fmt_ncl : nclusters_q;
    pending_ovf_d    = pending_ovf_q;
    if (capture)   pending_ovf_d = 1'b0;
    else if (drop) pending_ovf_d = 1'b1;
    drop_cnt_d       = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    frame_valid_d    = (state_d == SEND);
    frame_start_d    = capture;
    frame_overflow_d = 1'b0;
    frame_data_d     = '0;
    if (state_d == SEND) begin
      // Overflow flag is latched at capture and then carried across the frame.
      frame_overflow_d = capture ? pending_ovf_q : frame_overflow_q;
      frame_data_d     = {words_d[{beat_d, 1'b1}], words_d[{beat_d, 1'b0}]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      words_q          <= '{default: '0};
      nclusters_q      <= '0;
      pending_ovf_q    <= 1'b0;
      drop_cnt_q       <= '0;
      frame_valid_q    <= 1'b0;
      frame_start_q    <= 1'b0;
      frame_overflow_q <= 1'b0;
      frame_data_q     <= '0;
    end else begin
      words_q          <= words_d;
      nclusters_q      <= nclusters_d;
      pending_ovf_q    <= pending_ovf_d;
      drop_cnt_q       <= drop_cnt_d;
      frame_valid_q    <= frame_valid_d;
      frame_start_q    <= frame_start_d;
      frame_overflow_q <= frame_overflow_d;
      frame_data_q     <= frame_data_d;
    end
  end

  assign bus.frame_data     = frame_data_q;
  assign bus.frame_valid    = frame_valid_q;
  assign bus.frame_start    = frame_start_q;
  assign bus.frame_overflow = frame_overflow_q;
  assign bus.nclusters      = nclusters_q;
  assign bus.drop_cnt       = drop_cnt_q;
endmodule

// File: tb/tb_cluster_frame_packer.sv
// Bench for cluster_frame_packer: table of cluster sets with expected counts,
// scoreboard of expected beats, and directed drop / reset / saturation sequences.
module tb_cluster_frame_packer;
  logic clock = 1'b0;
  logic reset = 1'b1;

  cluster_frame_packer_if bus();
  cluster_frame_packer dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  vpf;
    logic [87:0] adr;
    logic [23:0] cnt;
    logic [3:0]  ncl;
  } vec_t;

  typedef struct packed {
    logic [27:0] data;
    logic        start;
    logic        ovf;
    logic [3:0]  ncl;
  } sb_t;

  int   tests = 0;
  int   fails = 0;
  sb_t  sbq[$];
  sb_t  mon_e;
  bit   sb_en = 1'b1;
  int   vld_cnt = 0, st_cnt = 0, ovf_cnt = 0;
  int   exp_drops = 0;
  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] exp_word(input vec_t v, input int i);
    logic [10:0] a;
    a = v.adr[11*i +: 11];
    if (v.vpf[i] && a <= 11'd1535) return {v.cnt[3*i +: 3], a};
    return {3'b000, 11'h7FE};
  endfunction

  function automatic logic [3:0] count_ncl(input vec_t v);
    int n = 0;
    for (int i = 0; i < 8; i++)
      if (v.vpf[i] && v.adr[11*i +: 11] <= 11'd1535) n++;
    return 4'(n);
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.vpf = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      v.adr[11*i +: 11] = 11'($urandom_range(0, 1700));
      v.cnt[3*i +: 3]   = 3'($urandom);
    end
    v.ncl = count_ncl(v);
    return v;
  endfunction

  task automatic push_frame(input vec_t v, input logic ovf);
    sb_t e;
    for (int b = 0; b < 4; b++) begin
      e.data  = {exp_word(v, 2*b+1), exp_word(v, 2*b)};
      e.start = (b == 0);
      e.ovf   = ovf;
      e.ncl   = v.ncl;
      sbq.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called 1ns after an edge; returns 1ns after the edge that sampled latch_in.
  task automatic latch_set(input vec_t v);
    bus.latch_in = 1'b1;
    bus.vpf_in   = v.vpf;
    bus.adr_in   = v.adr;
    bus.cnt_in   = v.cnt;
    @(posedge clock);
    #1;
    bus.latch_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.frame_valid), 64'(0));
    check({tag, "_start"}, 64'(bus.frame_start), 64'(0));
    check({tag, "_ovf"},   64'(bus.frame_overflow), 64'(0));
    check({tag, "_data"},  64'(bus.frame_data), 64'(0));
    check({tag, "_ncl"},   64'(bus.nclusters), 64'(0));
    check({tag, "_drops"}, 64'(bus.drop_cnt), 64'(0));
  endtask

  // Output monitor / scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.frame_valid) begin
        vld_cnt++;
        if (bus.frame_start)    st_cnt++;
        if (bus.frame_overflow) ovf_cnt++;
        if (sb_en) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: beat 0x%0h with no expected entry at %0t", bus.frame_data, $time);
          end else begin
            mon_e = sbq.pop_front();
            check("sb_data",  64'(bus.frame_data), 64'(mon_e.data));
            check("sb_start", 64'(bus.frame_start), 64'(mon_e.start));
            check("sb_ovf",   64'(bus.frame_overflow), 64'(mon_e.ovf));
            check("sb_ncl",   64'(bus.nclusters), 64'(mon_e.ncl));
          end
        end
      end else begin
        check("idle_outputs", 64'({bus.frame_data, bus.frame_start, bus.frame_overflow}), 64'(0));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    vec_t v, a, b, c, d;
    int   s0, st0, o0;

    bus.latch_in = 1'b0;
    bus.vpf_in   = '0;
    bus.adr_in   = '0;
    bus.cnt_in   = '0;

    // Table: sets with hand-derived legal-cluster counts.
    tbl[0] = '0;
    tbl[0].vpf = 8'h05;
    tbl[0].adr[10:0]  = 11'd10;   tbl[0].cnt[2:0] = 3'd2;
    tbl[0].adr[21:11] = 11'd77;   tbl[0].cnt[5:3] = 3'd5;
    tbl[0].adr[32:22] = 11'd1535; tbl[0].cnt[8:6] = 3'd7;
    tbl[0].ncl = 4'd2;
    tbl[1] = '0; tbl[1].vpf = 8'hFF; tbl[1].ncl = 4'd7;
    tbl[2] = '0; tbl[2].vpf = 8'h00; tbl[2].ncl = 4'd0;
    tbl[3] = '0; tbl[3].vpf = 8'hFF; tbl[3].ncl = 4'd8;
    tbl[4] = '0; tbl[4].vpf = 8'hA5; tbl[4].ncl = 4'd3;
    tbl[5] = '0; tbl[5].vpf = 8'h5A; tbl[5].ncl = 4'd3;
    for (int i = 0; i < 8; i++) begin
      tbl[1].adr[11*i +: 11] = 11'(100*i + 3);  tbl[1].cnt[3*i +: 3] = 3'(i);
      tbl[2].adr[11*i +: 11] = 11'(37*i + 5);   tbl[2].cnt[3*i +: 3] = 3'(7 - i);
      tbl[3].adr[11*i +: 11] = 11'(219*i);      tbl[3].cnt[3*i +: 3] = 3'(i + 1);
      tbl[4].adr[11*i +: 11] = 11'(200*i);      tbl[4].cnt[3*i +: 3] = 3'(i);
      tbl[5].adr[11*i +: 11] = 11'(1500 + i);   tbl[5].cnt[3*i +: 3] = 3'(6);
    end
    tbl[1].adr[87:77] = 11'd1600;
    tbl[3].adr[87:77] = 11'd1535;
    tbl[4].adr[65:55] = 11'd2047;
    tbl[5].adr[21:11] = 11'd1536;

    // Reset state.
    #12;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(2);

    // Table-driven frames with latency and hold checks.
    for (int k = 0; k < 6; k++) begin
      push_frame(tbl[k], 1'b0);
      latch_set(tbl[k]);
      check("lat_valid_b0", 64'(bus.frame_valid), 64'(1));
      check("lat_start_b0", 64'(bus.frame_start), 64'(1));
      check("ncl_b0",       64'(bus.nclusters), 64'(tbl[k].ncl));
      if (k == 0) check("t1_beat0", 64'(bus.frame_data), 64'(28'h1FF900A));
      tick(1);
      check("start_b1", 64'(bus.frame_start), 64'(0));
      if (k == 0) check("t1_beat1", 64'(bus.frame_data), 64'(28'h1FFBDFF));
      tick(2);
      check("valid_b3", 64'(bus.frame_valid), 64'(1));
      check("ncl_b3",   64'(bus.nclusters), 64'(tbl[k].ncl));
      tick(1);
      check("valid_after", 64'(bus.frame_valid), 64'(0));
      check("ncl_hold",    64'(bus.nclusters), 64'(tbl[k].ncl));
      tick(2);
    end

    // Nominal cadence: latch every 4 clocks -> contiguous frames.
    check("sb_empty_t2", 64'(sbq.size()), 64'(0));
    s0 = vld_cnt; st0 = st_cnt; o0 = ovf_cnt;
    for (int s = 0; s < 10; s++) begin
      v = rand_vec();
      push_frame(v, 1'b0);
      latch_set(v);
      tick(3);
    end
    tick(2);
    check("t2_valid_cycles", 64'(vld_cnt - s0), 64'(40));
    check("t2_starts",       64'(st_cnt - st0), 64'(10));
    check("t2_ovf_cycles",   64'(ovf_cnt - o0), 64'(0));
    check("t2_drops",        64'(bus.drop_cnt), 64'(0));

    // Drop at beat 1, back-to-back capture at beat 3.
    a = rand_vec(); b = rand_vec(); c = rand_vec(); d = rand_vec();
    push_frame(a, 1'b0);
    latch_set(a);
    tick(1);
    latch_set(b);
    exp_drops++;
    check("t3_drop_cnt", 64'(bus.drop_cnt), 64'(exp_drops));
    tick(1);
    push_frame(c, 1'b1);
    latch_set(c);
    check("t3_b2b_start", 64'(bus.frame_start), 64'(1));
    check("t3_b2b_ovf",   64'(bus.frame_overflow), 64'(1));
    tick(5);
    push_frame(d, 1'b0);
    latch_set(d);
    check("t3_next_ovf", 64'(bus.frame_overflow), 64'(0));
    tick(5);
    check("t3_drops_end", 64'(bus.drop_cnt), 64'(exp_drops));
    check("sb_empty_t3",  64'(sbq.size()), 64'(0));

    // Reset during beat 2 aborts the frame.
    v = rand_vec();
    push_frame(v, 1'b0);
    latch_set(v);
    tick(2);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    sbq.delete();
    exp_drops = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    s0 = vld_cnt;
    tick(3);
    check("t5_no_resume", 64'(vld_cnt - s0), 64'(0));
    v = rand_vec();
    push_frame(v, 1'b0);
    latch_set(v);
    check("t5_start", 64'(bus.frame_start), 64'(1));
    check("t5_beat0", 64'(bus.frame_data), 64'({exp_word(v, 1), exp_word(v, 0)}));
    tick(6);
    check("sb_empty_t5", 64'(sbq.size()), 64'(0));

    // Continuous latch_in: 3 drops per 4 clocks until drop_cnt saturates.
    sb_en = 1'b0;
    o0 = ovf_cnt;
    bus.vpf_in = tbl[3].vpf;
    bus.adr_in = tbl[3].adr;
    bus.cnt_in = tbl[3].cnt;
    bus.latch_in = 1'b1;
    tick(4);
    check("t6_drops_4clk", 64'(bus.drop_cnt), 64'(3));
    for (int cyc = 0; cyc < 100000 && bus.drop_cnt != 16'hFFFF; cyc++) tick(1);
    check("t6_saturate", 64'(bus.drop_cnt), 64'(16'hFFFF));
    tick(8);
    check("t6_sat_hold", 64'(bus.drop_cnt), 64'(16'hFFFF));
    bus.latch_in = 1'b0;
    tick(6);
    check("t6_idle",     64'(bus.frame_valid), 64'(0));
    check("t6_ovf_seen", 64'(ovf_cnt > o0), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
